uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Upstream stage of the UART receive path.
- Oversamples the serial `rx` line, deframes start/data/optional parity/stop bits, and presents the received byte on `rx_data`.
- Asserts `valid_reg` as a level that stays high until the next confirmed start bit.
- The downstream valid synchronizer turns that level into a one-cycle strobe, so the level semantics below are mandatory.

Parameters:
- CLK_DIV, 4, clk cycles per oversample tick (>=1).
- OVERSAMPLE, 16, ticks per bit period (even, >=4).
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  asynchronous serial input, idle high
- rx_data  out  DATA_BITS  last good received word, LSB-first on the line
- valid_reg  out  1  level: a good frame is held in rx_data
- frame_err  out  1  stop bit sampled low on the last frame
- parity_err  out  1  parity mismatch on the last frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high.
- Reset values:
  - rx_data = 0; valid_reg, frame_err, parity_err and busy = 0.
  - state = IDLE; both synchronizer flops = 1; all counters = 0.
- Input sync: rx passes through a 2-flop synchronizer to give rx_s. There is 2 clk of latency from the rx pin.
- Tick generation:
  - div_cnt counts 0..CLK_DIV-1; tick pulses for one clk when div_cnt == CLK_DIV-1.
  - div_cnt is held at 0 in IDLE, so tick phase aligns to the start edge.
- os_cnt counts ticks 0..OVERSAMPLE-1 within a bit. bit_cnt counts data bits 0..DATA_BITS-1.
- FSM:
  - IDLE: when rx_s == 0, go to START and clear div_cnt and os_cnt.
  - START:
    - On tick with os_cnt == OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - If rx_s == 1: glitch. Return to IDLE; all outputs unchanged.
    - If rx_s == 0: confirmed start. Clear valid_reg, frame_err and parity_err; clear os_cnt; go to DATA.
  - DATA:
    - On tick with os_cnt == OVERSAMPLE-1, shift rx_s into shift_reg from the MSB side (LSB-first line order) and increment bit_cnt.
    - After DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
  - PARITY:
    - Sample after one bit period.
    - parity_err_next = (XOR of data bits ^ sampled bit) != (PARITY == 2).
    - Go to STOP.
  - STOP: sample after one bit period.
    - If rx_s == 1: load rx_data from shift_reg. Set parity_err from the PARITY result. Set valid_reg = 1 only if there is no parity error. Go to IDLE.
    - If rx_s == 0: set frame_err = 1; valid_reg stays 0; rx_data unchanged; go to WAIT_IDLE.
  - WAIT_IDLE (break or framing recovery): stay until rx_s == 1, then go to IDLE.
- Latency: outputs update on the clk edge after the tick that samples mid stop bit. There is no separate handshake and no back-pressure.
- Data overwrite: a new good frame overwrites rx_data. The earlier clear of valid_reg at the confirmed start guarantees a 0->1 edge per frame.
- Priority: reset overrides everything. Reset mid-frame aborts to IDLE with all outputs cleared. The first frame after reset needs rx_s high in IDLE.
- Glitch rejection: a low pulse shorter than OVERSAMPLE/2 ticks never clears valid_reg.
- All counters are sized clog2 of their maximum value and must not wrap mid-bit.

Test Plan:
1. Default parameters (64 clk/bit). Send 0xA5 with stop=1 -> rx_data = 0xA5. valid_reg rises ~608 clk after the start edge (9.5 bits + sync) and stays high; frame_err = 0 and parity_err = 0.
2. After test 1, drive rx low for 20 clk, then high -> FSM returns to IDLE; valid_reg stays 1; rx_data stays 0xA5.
3. Back-to-back frames 0x00 then 0xFF with no idle gap -> valid_reg falls at the second start's mid-bit, then rises with rx_data = 0xFF.
4. Frame 0x3C with stop bit = 0, rx held low for 200 clk -> frame_err = 1, valid_reg = 0, rx_data keeps its old value, busy stays high until rx returns high.
5. PARITY = 2 (odd). Send 0x01 with parity bit 1 -> parity_err = 1, valid_reg = 0. Resend with parity bit 0 -> valid_reg = 1, rx_data = 0x01.
6. Assert reset during data bit 4 of a frame -> all outputs 0 on the next edge. The next full frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Receive deframer for the UART path. The serial rx line is synchronised,
//   oversampled, and split into start / data / optional parity / stop bits.
//   A good frame is presented on rx_data with valid_reg held high as a level
//   until the next confirmed start bit, so every frame produces a fresh 0->1
//   edge for the downstream strobe generator.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   rx_data     last good received word (LSB first on the line)
//   valid_reg   level: a good frame is held in rx_data
//   frame_err   stop bit sampled low on the last frame
//   parity_err  parity mismatch on the last frame
//   busy        high whenever the FSM is not in IDLE
//
// State table
//   state     | meaning
//   IDLE      | line idle, waiting for a low level on rx_s
//   START     | qualifying the start bit at its midpoint
//   DATA      | sampling DATA_BITS data bits, LSB first
//   PARITY    | sampling the parity bit (only when PARITY != 0)
//   STOP      | sampling the stop bit, committing results
//   WAIT_IDLE | framing error / break, waiting for the line to go high

module uart_rx_frame #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid_reg,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t state, state_next;

  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;

  logic tick;
  logic start_smp;
  logic bit_smp;

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (!rx_s) state_next = S_START;
      S_START:     if (start_smp) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (bit_smp && (bit_cnt == BIT_LAST))
                     state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (bit_smp) state_next = S_STOP;
      S_STOP:      if (bit_smp) state_next = rx_s ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // FSM: outputs and sample strobes
  always_comb begin
    busy      = (state != S_IDLE);
    tick      = busy && (div_cnt == DIV_LAST);
    // Start bit is qualified half a bit in; every later bit is sampled one
    // full bit period after the previous sample, i.e. at its midpoint.
    start_smp = (state == S_START) && tick && (os_cnt == OS_MID);
    bit_smp   = tick && (os_cnt == OS_LAST) &&
                ((state == S_DATA) || (state == S_PARITY) || (state == S_STOP));
  end

  // Counters. Holding them at zero in IDLE aligns the tick phase to the
  // start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (start_smp && !rx_s)
        os_cnt <= '0;
      else if (tick)
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      if (bit_smp && (state == S_DATA))
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      rx_data    <= '0;
      valid_reg  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // Clearing on a confirmed start guarantees a 0->1 valid edge per frame;
      // a rejected glitch leaves every output alone.
      if (start_smp && !rx_s) begin
        valid_reg  <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
        par_bad    <= 1'b0;
      end
      if (bit_smp && (state == S_DATA))
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (bit_smp && (state == S_PARITY))
        par_bad <= ((^shift_reg) ^ rx_s) != (PARITY == 2);
      if (bit_smp && (state == S_STOP)) begin
        if (rx_s) begin
          rx_data    <= shift_reg;
          parity_err <= par_bad;
          valid_reg  <= !par_bad;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
//   Two receivers share one clock: dut0 without parity, dut1 with odd parity.
//   Frames are built bit by bit at 64 clk per bit. The expected outcome of
//   each frame is pushed into a per-instance queue when it is sent; a monitor
//   pops and compares whenever valid_reg, frame_err or parity_err rises.

module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst0, rst1, rx0, rx1;
  logic [7:0] rx_data0, rx_data1;
  logic valid0, fe0, pe0, busy0;
  logic valid1, fe1, pe1, busy1;

  uart_rx_frame #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk(clk), .reset(rst0), .rx(rx0), .rx_data(rx_data0),
    .valid_reg(valid0), .frame_err(fe0), .parity_err(pe0), .busy(busy0)
  );

  uart_rx_frame #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2)) dut1 (
    .clk(clk), .reset(rst1), .rx(rx1), .rx_data(rx_data1),
    .valid_reg(valid1), .frame_err(fe1), .parity_err(pe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] last_good [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int evt_cyc0 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitors
  logic pv0 = 1'b0, pf0 = 1'b0, pp0 = 1'b0;
  logic pv1 = 1'b0, pf1 = 1'b0, pp1 = 1'b0;

  always @(negedge clk) begin
    if ((valid0 && !pv0) || (fe0 && !pf0) || (pe0 && !pp0)) begin
      evt_cyc0 = cyc;
      chk("evt0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("evt0_valid", 32'(valid0), 32'(e0.valid));
        chk("evt0_frame_err", 32'(fe0), 32'(e0.fe));
        chk("evt0_parity_err", 32'(pe0), 32'(e0.pe));
        chk("evt0_rx_data", 32'(rx_data0), 32'(e0.data));
      end
    end
    pv0 = valid0; pf0 = fe0; pp0 = pe0;
  end

  always @(negedge clk) begin
    if ((valid1 && !pv1) || (fe1 && !pf1) || (pe1 && !pp1)) begin
      chk("evt1_expected", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("evt1_valid", 32'(valid1), 32'(e1.valid));
        chk("evt1_frame_err", 32'(fe1), 32'(e1.fe));
        chk("evt1_parity_err", 32'(pe1), 32'(e1.pe));
        chk("evt1_rx_data", 32'(rx_data1), 32'(e1.data));
      end
    end
    pv1 = valid1; pf1 = fe1; pp1 = pe1;
  end

  task automatic drive(input int inst, input logic b);
    if (inst == 0) rx0 = b; else rx1 = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle(input int inst, input int n);
    if (inst == 0) rx0 = 1'b1; else rx1 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: outcome of a frame from its content alone.
  // dut1 uses odd parity: data ones plus parity bit must be odd.
  task automatic send_frame(input int inst, input logic [7:0] d,
                            input logic pbit, input logic stop);
    exp_t e;
    bit   par_ok;
    par_ok = (inst == 0) || ((($countones(d) + int'(pbit)) % 2) == 1);
    if (!stop) begin
      e.valid = 1'b0; e.fe = 1'b1; e.pe = 1'b0; e.data = last_good[inst];
    end else if (!par_ok) begin
      e.valid = 1'b0; e.fe = 1'b0; e.pe = 1'b1; e.data = d;
      last_good[inst] = d;
    end else begin
      e.valid = 1'b1; e.fe = 1'b0; e.pe = 1'b0; e.data = d;
      last_good[inst] = d;
    end
    if (inst == 0) begin
      q0.push_back(e);
      start_cyc = cyc;
    end else begin
      q1.push_back(e);
    end
    drive(inst, 1'b0);
    // Start bit has been confirmed by now: status must be cleared.
    if (inst == 0) begin
      chk("start0_valid_clr", 32'(valid0), 0);
      chk("start0_fe_clr", 32'(fe0), 0);
      chk("start0_pe_clr", 32'(pe0), 0);
    end else begin
      chk("start1_valid_clr", 32'(valid1), 0);
      chk("start1_fe_clr", 32'(fe1), 0);
      chk("start1_pe_clr", 32'(pe1), 0);
    end
    for (int i = 0; i < 8; i++) drive(inst, d[i]);
    if (inst == 1) drive(inst, pbit);
    drive(inst, stop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int lat;
    rx0 = 1'b1; rx1 = 1'b1; rst0 = 1'b1; rst1 = 1'b1;
    last_good[0] = 8'h00; last_good[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data0), 0);
    chk("reset_valid", 32'(valid0), 0);
    chk("reset_frame_err", 32'(fe0), 0);
    chk("reset_parity_err", 32'(pe0), 0);
    chk("reset_busy", 32'(busy0), 0);
    chk("reset_busy1", 32'(busy1), 0);
    rst0 = 1'b0; rst1 = 1'b0;
    idle(0, 10);

    // Single good frame and its latency from the start edge.
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle(0, 20);
    lat = evt_cyc0 - start_cyc;
    chk("t1_latency_window", 32'((lat >= 600) && (lat <= 620)), 1);
    chk("t1_valid_held", 32'(valid0), 1);
    chk("t1_rx_data", 32'(rx_data0), 32'h A5);

    // Short low glitch is rejected without touching outputs.
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_busy_in_glitch", 32'(busy0), 1);
    rx0 = 1'b1;
    repeat (60) @(negedge clk);
    chk("t2_busy_after", 32'(busy0), 0);
    chk("t2_valid_kept", 32'(valid0), 1);
    chk("t2_rx_data_kept", 32'(rx_data0), 32'h A5);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    idle(0, 20);
    chk("t3_rx_data", 32'(rx_data0), 32'h FF);

    // Framing error followed by a held-low break.
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    chk("t4_busy_in_break", 32'(busy0), 1);
    chk("t4_frame_err", 32'(fe0), 1);
    chk("t4_valid", 32'(valid0), 0);
    chk("t4_rx_data_kept", 32'(rx_data0), 32'h FF);
    rx0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4_busy_released", 32'(busy0), 0);

    // Odd parity on dut1.
    send_frame(1, 8'h01, 1'b1, 1'b1);
    idle(1, 20);
    chk("t5_parity_err", 32'(pe1), 1);
    chk("t5_valid_low", 32'(valid1), 0);
    send_frame(1, 8'h01, 1'b0, 1'b1);
    idle(1, 20);
    chk("t5_valid", 32'(valid1), 1);
    chk("t5_rx_data", 32'(rx_data1), 1);
    chk("t5_parity_ok", 32'(pe1), 0);

    // Reset in the middle of data bit 4.
    d = 8'hC3;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, d[i]);
    rx0 = d[4];
    repeat (32) @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_rx_data", 32'(rx_data0), 0);
    chk("t6_rst_valid", 32'(valid0), 0);
    chk("t6_rst_frame_err", 32'(fe0), 0);
    chk("t6_rst_parity_err", 32'(pe0), 0);
    chk("t6_rst_busy", 32'(busy0), 0);
    rx0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    last_good[0] = 8'h00;
    idle(0, 20);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    idle(0, 20);
    chk("t6_rx_data", 32'(rx_data0), 32'h 5A);
    chk("t6_valid", 32'(valid0), 1);

    // Randomised traffic on both receivers in parallel.
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          logic [7:0] rd;
          logic       st;
          rd = 8'($urandom);
          st = ($urandom_range(0, 4) != 0);
          send_frame(0, rd, 1'b0, st);
          idle(0, st ? int'($urandom_range(0, 40)) : int'($urandom_range(10, 40)));
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          logic [7:0] rd;
          logic       pb;
          rd = 8'($urandom);
          pb = 1'($urandom_range(0, 1));
          send_frame(1, rd, pb, 1'b1);
          idle(1, int'($urandom_range(0, 40)));
        end
      end
    join

    idle(0, 100);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
